// File: rtl/pe_tile_pkg.sv
// pe_tile_pkg: shared definitions for the parametrised PE tile.
//   - side enumeration and flat track numbering helper
//   - config register indices
//   - PE op codes and switch-box source codes
//   - bit positions of fields inside config words
package pe_tile_pkg;

    typedef enum logic [1:0] {
        SIDE_N = 2'd0,
        SIDE_E = 2'd1,
        SIDE_S = 2'd2,
        SIDE_W = 2'd3
    } side_e;

    // Config register indices (config_addr[15:0])
    localparam logic [15:0] REG_SB_N = 16'd0;
    localparam logic [15:0] REG_SB_E = 16'd1;
    localparam logic [15:0] REG_SB_S = 16'd2;
    localparam logic [15:0] REG_SB_W = 16'd3;
    localparam logic [15:0] REG_CB0  = 16'd4;
    localparam logic [15:0] REG_CB1  = 16'd5;
    localparam logic [15:0] REG_PE   = 16'd6;

    // PE op codes; 6 and 7 produce zero
    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_OR     = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_PASS_A = 3'd5;

    // Switch-box source codes for an output on side s
    localparam logic [1:0] SRC_NEXT = 2'd0;  // in side (s+1)%4
    localparam logic [1:0] SRC_OPP  = 2'd1;  // in side (s+2)%4
    localparam logic [1:0] SRC_PREV = 2'd2;  // in side (s+3)%4
    localparam logic [1:0] SRC_PE   = 2'd3;  // PE result

    // Field positions inside config words
    localparam int unsigned SB_REG_EN_LSB = 16;
    localparam int unsigned PE_REG_EN_BIT = 8;

    // Flat track number used for in_wires/out_wires packing
    function automatic int unsigned flat_track(input int unsigned side,
                                               input int unsigned track,
                                               input int unsigned num_tracks);
        return side * num_tracks + track;
    endfunction

endpackage

// File: rtl/pe_tile_param_if.sv
// pe_tile_param_if: memory-mapped configuration bus of the PE tile.
//   config_addr      [31:16] tile match, [15:0] register index
//   config_data      write data
//   config_valid     write strobe
//   config_read      read strobe
//   config_read_data registered readback (driven by the tile)
// master: the configuration controller; slave: the tile.
interface pe_tile_param_if;

    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_valid;
    logic        config_read;
    logic [31:0] config_read_data;

    modport master (
        output config_addr,
        output config_data,
        output config_valid,
        output config_read,
        input  config_read_data
    );

    modport slave (
        input  config_addr,
        input  config_data,
        input  config_valid,
        input  config_read,
        output config_read_data
    );

endinterface

// File: rtl/pe_tile_config_regs.sv
// pe_tile_config_regs: address match, config register file and readback.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   tile_id      static tile address compared with config_addr[31:16]
//   cfg          config bus (slave side); drives config_read_data
//   sb_src       per side/track switch-box source code
//   sb_reg_en    per side/track switch-box register enable
//   cb0_sel      flat track feeding PE operand a
//   cb1_sel      flat track feeding PE operand b
//   pe_op        PE operation
//   pe_reg_en    PE output register enable
// Fields are stored at their exact width, so writes are implicitly masked and
// unmapped indices neither store nor read back anything.
module pe_tile_config_regs
    import pe_tile_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int SEL_W      = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [15:0]                        tile_id,
    pe_tile_param_if.slave                     cfg,
    output logic [3:0][NUM_TRACKS-1:0][1:0]    sb_src,
    output logic [3:0][NUM_TRACKS-1:0]         sb_reg_en,
    output logic [SEL_W-1:0]                   cb0_sel,
    output logic [SEL_W-1:0]                   cb1_sel,
    output logic [2:0]                         pe_op,
    output logic                               pe_reg_en
);

    logic [3:0][NUM_TRACKS-1:0][1:0] sb_src_q;
    logic [3:0][NUM_TRACKS-1:0]      sb_en_q;
    logic [SEL_W-1:0]                cb0_q;
    logic [SEL_W-1:0]                cb1_q;
    logic [2:0]                      pe_op_q;
    logic                            pe_en_q;

    logic        match;
    logic [15:0] idx;
    logic [31:0] rd_word;
    logic        unused_data;

    assign match = (cfg.config_addr[31:16] == tile_id);
    assign idx   = cfg.config_addr[15:0];

    // Only the low bits of config_data land in any field.
    assign unused_data = ^cfg.config_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_src_q <= '0;
            sb_en_q  <= '0;
            cb0_q    <= '0;
            cb1_q    <= '0;
            pe_op_q  <= '0;
            pe_en_q  <= 1'b0;
        end else if (cfg.config_valid && match) begin
            case (idx)
                REG_SB_N, REG_SB_E, REG_SB_S, REG_SB_W: begin
                    for (int t = 0; t < NUM_TRACKS; t++) begin
                        sb_src_q[idx[1:0]][t] <= cfg.config_data[2*t +: 2];
                        sb_en_q[idx[1:0]][t]  <= cfg.config_data[SB_REG_EN_LSB + t];
                    end
                end
                REG_CB0: cb0_q <= cfg.config_data[SEL_W-1:0];
                REG_CB1: cb1_q <= cfg.config_data[SEL_W-1:0];
                REG_PE: begin
                    pe_op_q <= cfg.config_data[2:0];
                    pe_en_q <= cfg.config_data[PE_REG_EN_BIT];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (idx)
            REG_SB_N, REG_SB_E, REG_SB_S, REG_SB_W: begin
                for (int t = 0; t < NUM_TRACKS; t++) begin
                    rd_word[2*t +: 2]            = sb_src_q[idx[1:0]][t];
                    rd_word[SB_REG_EN_LSB + t]   = sb_en_q[idx[1:0]][t];
                end
            end
            REG_CB0: rd_word[SEL_W-1:0] = cb0_q;
            REG_CB1: rd_word[SEL_W-1:0] = cb1_q;
            REG_PE: begin
                rd_word[2:0]          = pe_op_q;
                rd_word[PE_REG_EN_BIT] = pe_en_q;
            end
            default: ;
        endcase
    end

    // Readback samples the pre-write value when read and write coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg.config_read_data <= '0;
        end else begin
            cfg.config_read_data <= (cfg.config_read && match) ? rd_word : '0;
        end
    end

    assign sb_src    = sb_src_q;
    assign sb_reg_en = sb_en_q;
    assign cb0_sel   = cb0_q;
    assign cb1_sel   = cb1_q;
    assign pe_op     = pe_op_q;
    assign pe_reg_en = pe_en_q;

endmodule

// File: rtl/pe_tile_param.sv
// pe_tile_param: uniform processing-element tile.
// A 4-side switch box (per-track optional output register), two connect
// boxes selecting PE operands from any input track, a small ALU PE with an
// optional output register, and a config register file with readback.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   tile_id      static tile address
//   cfg          config bus (slave): addr/data/valid/read in, read_data out
//   in_wires     4*NUM_TRACKS tracks of TRACK_WIDTH bits, side-major (N,E,S,W)
//   out_wires    same packing as in_wires
module pe_tile_param
    import pe_tile_pkg::*;
#(
    parameter int TRACK_WIDTH = 1,
    parameter int NUM_TRACKS  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [15:0]                            tile_id,
    pe_tile_param_if.slave                         cfg,
    input  logic [4*NUM_TRACKS*TRACK_WIDTH-1:0]    in_wires,
    output logic [4*NUM_TRACKS*TRACK_WIDTH-1:0]    out_wires
);

    localparam int NUM_FLAT = 4 * NUM_TRACKS;
    localparam int SEL_W    = $clog2(NUM_FLAT);

    logic [3:0][NUM_TRACKS-1:0][1:0] sb_src;
    logic [3:0][NUM_TRACKS-1:0]      sb_reg_en;
    logic [SEL_W-1:0]                cb0_sel;
    logic [SEL_W-1:0]                cb1_sel;
    logic [2:0]                      pe_op;
    logic                            pe_reg_en;

    logic [TRACK_WIDTH-1:0] a_p0;
    logic [TRACK_WIDTH-1:0] b_p0;
    logic [TRACK_WIDTH-1:0] pe_res_p0;
    logic [TRACK_WIDTH-1:0] pe_res_p1;
    logic [TRACK_WIDTH-1:0] pe_out;

    // Modulo-2^TRACK_WIDTH ALU; carry/borrow fall off the top.
    function automatic logic [TRACK_WIDTH-1:0] pe_alu(input logic [2:0]             op,
                                                      input logic [TRACK_WIDTH-1:0] a,
                                                      input logic [TRACK_WIDTH-1:0] b);
        case (op)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_PASS_A: return a;
            default:   return '0;
        endcase
    endfunction

    pe_tile_config_regs #(
        .NUM_TRACKS (NUM_TRACKS),
        .SEL_W      (SEL_W)
    ) u_config_regs (
        .clk       (clk),
        .reset     (reset),
        .tile_id   (tile_id),
        .cfg       (cfg),
        .sb_src    (sb_src),
        .sb_reg_en (sb_reg_en),
        .cb0_sel   (cb0_sel),
        .cb1_sel   (cb1_sel),
        .pe_op     (pe_op),
        .pe_reg_en (pe_reg_en)
    );

    // Connect boxes: selects beyond the last flat track read as zero
    // (possible when 4*NUM_TRACKS is not a power of two).
    always_comb begin
        a_p0 = '0;
        b_p0 = '0;
        for (int i = 0; i < NUM_FLAT; i++) begin
            if (cb0_sel == SEL_W'(i)) a_p0 = in_wires[i*TRACK_WIDTH +: TRACK_WIDTH];
            if (cb1_sel == SEL_W'(i)) b_p0 = in_wires[i*TRACK_WIDTH +: TRACK_WIDTH];
        end
    end

    assign pe_res_p0 = pe_alu(pe_op, a_p0, b_p0);

    // ---- stage p0 -> p1: optional PE output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pe_res_p1 <= '0;
        end else begin
            pe_res_p1 <= pe_res_p0;
        end
    end

    assign pe_out = pe_reg_en ? pe_res_p1 : pe_res_p0;

    // Switch box
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
            localparam int NEXT_LSB = flat_track((s + 1) % 4, t, NUM_TRACKS) * TRACK_WIDTH;
            localparam int OPP_LSB  = flat_track((s + 2) % 4, t, NUM_TRACKS) * TRACK_WIDTH;
            localparam int PREV_LSB = flat_track((s + 3) % 4, t, NUM_TRACKS) * TRACK_WIDTH;
            localparam int OUT_LSB  = flat_track(s, t, NUM_TRACKS) * TRACK_WIDTH;

            logic [TRACK_WIDTH-1:0] route_p0;
            logic [TRACK_WIDTH-1:0] route_p1;

            always_comb begin
                route_p0 = '0;
                case (sb_src[s][t])
                    SRC_NEXT: route_p0 = in_wires[NEXT_LSB +: TRACK_WIDTH];
                    SRC_OPP:  route_p0 = in_wires[OPP_LSB  +: TRACK_WIDTH];
                    SRC_PREV: route_p0 = in_wires[PREV_LSB +: TRACK_WIDTH];
                    default:  route_p0 = pe_out;
                endcase
            end

            // ---- stage p0 -> p1: optional track register ----
            always_ff @(posedge clk) begin
                if (reset) begin
                    route_p1 <= '0;
                end else begin
                    route_p1 <= route_p0;
                end
            end

            assign out_wires[OUT_LSB +: TRACK_WIDTH] = sb_reg_en[s][t] ? route_p1 : route_p0;
        end
    end

endmodule

// File: tb/tb_pe_tile_param.sv
// Directed bench for pe_tile_param with TRACK_WIDTH=8, NUM_TRACKS=4.
module tb_pe_tile_param;
    import pe_tile_pkg::*;

    localparam int TW = 8;
    localparam int NT = 4;
    localparam logic [15:0] TID = 16'h0012;

    logic               clk;
    logic               reset;
    logic [15:0]        tile_id;
    logic [4*NT*TW-1:0] in_wires;
    logic [4*NT*TW-1:0] out_wires;

    pe_tile_param_if bus ();

    pe_tile_param #(
        .TRACK_WIDTH (TW),
        .NUM_TRACKS  (NT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tile_id   (tile_id),
        .cfg       (bus),
        .in_wires  (in_wires),
        .out_wires (out_wires)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input int s, input int t, input logic [TW-1:0] v);
        in_wires[(s*NT+t)*TW +: TW] = v;
        #1;
    endtask

    function automatic logic [31:0] out_trk(input int s, input int t);
        return {24'd0, out_wires[(s*NT+t)*TW +: TW]};
    endfunction

    task automatic cfg_write(input logic [15:0] tid, input logic [15:0] idx, input logic [31:0] d);
        bus.config_addr  = {tid, idx};
        bus.config_data  = d;
        bus.config_valid = 1'b1;
        tick();
        bus.config_valid = 1'b0;
        #1;
    endtask

    task automatic cfg_read(input logic [15:0] tid, input logic [15:0] idx);
        bus.config_addr = {tid, idx};
        bus.config_read = 1'b1;
        tick();
        bus.config_read = 1'b0;
        #1;
    endtask

    initial begin
        tile_id          = TID;
        in_wires         = '0;
        bus.config_addr  = '0;
        bus.config_data  = '0;
        bus.config_valid = 1'b0;
        bus.config_read  = 1'b0;
        reset            = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state and default routing
        check("rst_readback", bus.config_read_data, 32'h0);
        set_in(SIDE_E, 2, 8'd1);
        check("default_E2_to_N2", out_trk(SIDE_N, 2), 32'd1);
        check("default_N1_zero", out_trk(SIDE_N, 1), 32'd0);
        set_in(SIDE_E, 2, 8'd0);

        // Registered PE add feeding N0
        cfg_write(TID, REG_CB0, 32'd0);
        cfg_write(TID, REG_CB1, 32'd1);
        cfg_write(TID, REG_PE, 32'h100);
        cfg_write(TID, REG_SB_N, 32'h3);
        set_in(SIDE_N, 0, 8'd200);
        set_in(SIDE_N, 1, 8'd100);
        check("pe_reg_before_edge", out_trk(SIDE_N, 0), 32'd0);
        tick();
        check("pe_reg_add_wrap", out_trk(SIDE_N, 0), 32'd44);

        // Registered switch-box track S0 sourced from W0
        cfg_write(TID, REG_SB_S, 32'h0001_0000);
        set_in(SIDE_W, 0, 8'hAA);
        check("sb_reg_S0_hold", out_trk(SIDE_S, 0), 32'd0);
        tick();
        check("sb_reg_S0_late", out_trk(SIDE_S, 0), 32'hAA);
        set_in(SIDE_W, 0, 8'h00);
        check("sb_reg_S0_keep", out_trk(SIDE_S, 0), 32'hAA);
        tick();
        check("sb_reg_S0_clear", out_trk(SIDE_S, 0), 32'h0);
        cfg_read(TID, REG_SB_S);
        check("read_idx2", bus.config_read_data, 32'h0001_0000);

        // Foreign tile address: no effect, readback zero
        cfg_write(16'h00FF, REG_SB_S, 32'h0);
        cfg_write(16'h00FF, REG_SB_N, 32'h0);
        set_in(SIDE_W, 0, 8'h11);
        check("foreign_S0_still_reg", out_trk(SIDE_S, 0), 32'h0);
        check("foreign_N0_still_pe", out_trk(SIDE_N, 0), 32'd44);
        set_in(SIDE_W, 0, 8'h00);
        cfg_read(16'h00FF, REG_SB_S);
        check("foreign_read_zero", bus.config_read_data, 32'h0);

        // Unmapped index
        cfg_write(TID, 16'd7, 32'hFFFF_FFFF);
        cfg_read(TID, 16'd7);
        check("unmapped_read_zero", bus.config_read_data, 32'h0);

        // Simultaneous write and read at the PE register
        bus.config_addr  = {TID, REG_PE};
        bus.config_data  = 32'h5;
        bus.config_valid = 1'b1;
        bus.config_read  = 1'b1;
        tick();
        bus.config_valid = 1'b0;
        bus.config_read  = 1'b0;
        #1;
        check("rw_same_old_value", bus.config_read_data, 32'h100);
        cfg_read(TID, REG_PE);
        check("rw_next_new_value", bus.config_read_data, 32'h5);

        // Combinational PE ops, a=200 (0xC8), b=100 (0x64)
        check("op_pass_a", out_trk(SIDE_N, 0), 32'hC8);
        cfg_write(TID, REG_PE, 32'h1);
        check("op_sub", out_trk(SIDE_N, 0), 32'h64);
        cfg_write(TID, REG_PE, 32'h2);
        check("op_and", out_trk(SIDE_N, 0), 32'h40);
        cfg_write(TID, REG_PE, 32'h3);
        check("op_or", out_trk(SIDE_N, 0), 32'hEC);
        cfg_write(TID, REG_PE, 32'h4);
        check("op_xor", out_trk(SIDE_N, 0), 32'hAC);
        cfg_write(TID, REG_PE, 32'h6);
        check("op_6_zero", out_trk(SIDE_N, 0), 32'h0);
        cfg_write(TID, REG_CB1, 32'd13);
        cfg_write(TID, REG_PE, 32'h0);
        set_in(SIDE_W, 1, 8'h05);
        check("cb1_flat13_add", out_trk(SIDE_N, 0), 32'hCD);
        set_in(SIDE_W, 1, 8'h00);

        // Reset while the PE register holds 0x7F
        cfg_write(TID, REG_PE, 32'h105);
        set_in(SIDE_N, 0, 8'h7F);
        tick();
        check("pe_reg_holds_7f", out_trk(SIDE_N, 0), 32'h7F);
        bus.config_addr = {TID, REG_PE};
        bus.config_read = 1'b1;
        tick();
        check("readback_before_reset", bus.config_read_data, 32'h105);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.config_read = 1'b0;
        #1;
        check("reset_readback_zero", bus.config_read_data, 32'h0);
        set_in(SIDE_E, 0, 8'h33);
        check("reset_default_N0", out_trk(SIDE_N, 0), 32'h33);
        set_in(SIDE_W, 0, 8'h5A);
        check("reset_default_S0_comb", out_trk(SIDE_S, 0), 32'h5A);
        cfg_read(TID, REG_PE);
        check("reset_pe_cfg_zero", bus.config_read_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_tile_param.md
# pe_tile_param

Parametrised processing-element tile: a 4-side switch box with per-track optional pipeline registers, two connect boxes feeding a small ALU PE with optional output register, and a memory-mapped config register file with readback. It replaces the fixed 1-bit, 4-track, corner-specific tiles and is instantiated uniformly at every array position, with `tile_id` strapped per position.

## Interface
Parameters:
- `TRACK_WIDTH`, default 1: bits per track, 1..16.
- `NUM_TRACKS`, default 4: tracks per side, 1..8.

Ports:
- `clk`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high.
- `tile_id`, input, 16: static tile address.
- `config_addr`, input, 32: [31:16] tile match, [15:0] register index.
- `config_data`, input, 32: write data.
- `config_valid`, input, 1: write strobe.
- `config_read`, input, 1: read strobe.
- `config_read_data`, output, 32: registered readback.
- `in_wires`, input, 4·NUM_TRACKS·TRACK_WIDTH: side s, track t at slice [(s·NUM_TRACKS+t)·TRACK_WIDTH +: TRACK_WIDTH]. Sides: 0=N, 1=E, 2=S, 3=W.
- `out_wires`, output, 4·NUM_TRACKS·TRACK_WIDTH: same packing as `in_wires`.

## Operation
- Match: `config_addr[31:16] == tile_id`.
- Write: on `config_valid` && match, register[index] <= `config_data`, masked to the field width.
- Read: `config_read_data` <= register[index] if `config_read` && match, else 0.
- Unmapped index: writes are ignored and reads return 0.
- Register map:
  - Index 0..3: SB side s. Bits [2t+1:2t] give the source for output track t. Bit 16+t is the register enable for that track.
  - Index 4: CB0 select, log2(4·NUM_TRACKS) bits, flat track number into `in_wires`.
  - Index 5: CB1 select, same format as index 4.
  - Index 6: PE. Bits [2:0] op, bit 8 output register enable.
- SB source codes for output side s, track t:
  - 0 = in side (s+1)%4, track t.
  - 1 = in side (s+2)%4, track t.
  - 2 = in side (s+3)%4, track t.
  - 3 = PE result, zero-extended or truncated to TRACK_WIDTH.
- PE operands: a = CB0 track, b = CB1 track.
- PE ops: 0 a+b, 1 a−b, 2 a&b, 3 a|b, 4 a^b, 5 a. Ops 6 and 7 output 0. All arithmetic is modulo 2^TRACK_WIDTH; carry and borrow are dropped.
- PE result is combinational when the output register enable is 0, else a flop.
- SB track output is combinational when its register enable is 0, else a flop.
- Combinational loops through neighbouring tiles are a software responsibility; the block has no loop detection.

## Timing
- Reset: all config registers 0, all pipeline flops 0, `config_read_data` 0.
- After reset, each output track t of side s routes in side (s+1)%4 track t combinationally. The PE runs op 0 (add) on flat tracks 0 and 0.
- A config write takes effect from the cycle after the strobe edge.
- A read returns data one cycle after the strobe.
- Read and write to the same index in the same cycle: the read returns the old value.
- Registered PE: +1 cycle from CB input to PE result.
- Registered SB track: +1 cycle. A path through a registered PE and a registered SB track takes 2 cycles.
- Pipeline flops load every cycle; there is no stall or enable.
- Reset mid-operation clears configuration and pipeline flops in the same edge. Outputs return to the default routing the following cycle.
- Toggling a register enable mid-stream: the new path is valid the next cycle. The flop holds its last captured value until it is bypassed or reloaded.

## Structure
- `pe_tile_pkg` holds: side enum, register index constants, op code constants, SB source codes.
- Sub-module `pe_tile_config_regs` holds the address match, config register file and readback register. It exports decoded fields to the datapath.

## Test plan
- Reset, then drive in side E track 2 = 1: out side N track 2 = 1 combinationally. `config_read_data` = 0.
- TRACK_WIDTH=8:
  - Write index 4 = 0, index 5 = 1, index 6 = 0x100 (add, registered), index 0 bits[1:0] = 3.
  - Drive in N0 = 200, N1 = 100.
  - Required: out N0 = 44 exactly 1 cycle later.
- Write index 2 = 0x0001_0000 (S track 0 registered, source code 0 = W).
  - Required: a pulse on in W0 appears on out S0 one cycle late.
  - Read index 2 returns 0x0001_0000 one cycle after the read strobe.
- Write with `config_addr[31:16]` ≠ `tile_id`: all routing is unchanged and a matching-index read returns 0.
- Simultaneous write 0x5 and read at index 6: the readback returns the prior value. A read on the next cycle returns 0x5.
- Assert `reset` while the PE register holds 0x7F: `config_read_data` and all flops are 0 next cycle, and default routing is restored.
